alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - Moore FSM that sequences register reads, an ALU launch and writeback
module alu_op_sequencer #(
  parameter int REG_ADDR_W = 3,
  parameter int OPCODE_W   = 4,
  parameter int TIMEOUT    = 15,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  imm_mode,
  input  logic                  alu_ready,
  output logic                  reg1_out,
  output logic                  reg2_out,
  output logic [REG_ADDR_W-1:0] reg1_addr,
  output logic [REG_ADDR_W-1:0] reg2_addr,
  output logic [REG_ADDR_W-1:0] reg_dest_addr,
  output logic [OPCODE_W-1:0]   alu_op,
  output logic                  imm_sel,
  output logic                  alu_start,
  output logic                  alu_out_en,
  output logic                  reg_dest,
  output logic                  pc_increment,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ1 = 3'd1,
    S_READ2 = 3'd2,
    S_EXEC  = 3'd3,
    S_WAIT  = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6,
    S_ERROR = 3'd7
  } state_t;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [OPCODE_W-1:0]   opcode_q, opcode_d;
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
  logic [REG_ADDR_W-1:0] rs2_q, rs2_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  imm_q, imm_d;
  logic                  dest_is_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opcode_q <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      imm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opcode_q <= opcode_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
    end
  end

  assign dest_is_zero = (ZERO_REG != 0) && (rd_q == '0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    opcode_d     = opcode_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    imm_d        = imm_q;
    reg1_out     = 1'b0;
    reg2_out     = 1'b0;
    alu_start    = 1'b0;
    alu_out_en   = 1'b0;
    reg_dest     = 1'b0;
    pc_increment = 1'b0;
    busy         = (state_q != S_IDLE);
    done         = 1'b0;
    err          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          opcode_d = opcode;
          rs1_d    = rs1;
          rs2_d    = rs2;
          rd_d     = rd;
          imm_d    = imm_mode;
          state_d  = S_READ1;
        end
      end
      S_READ1: begin
        reg1_out = 1'b1;
        state_d  = imm_q ? S_EXEC : S_READ2;
      end
      S_READ2: begin
        reg2_out = 1'b1;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        alu_start = 1'b1;
        state_d   = alu_ready ? S_WRITE : S_WAIT;
      end
      S_WAIT: begin
        // A late result wins over the timeout when both land in the same cycle.
        if (alu_ready) begin
          state_d = S_WRITE;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      S_WRITE: begin
        alu_out_en   = 1'b1;
        pc_increment = 1'b1;
        reg_dest     = !dest_is_zero;
        state_d      = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign reg1_addr     = rs1_q;
  assign reg2_addr     = rs2_q;
  assign reg_dest_addr = rd_q;
  assign alu_op        = opcode_q;
  assign imm_sel       = imm_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

  localparam int AW  = 3;
  localparam int OW  = 4;
  localparam int TMO = 15;

  typedef struct packed {
    logic r1, r2, as, oe, rdst, pc, busy, done, err, imm;
    logic [AW-1:0] a1, a2, ad;
    logic [OW-1:0] op;
  } exp_t;

  typedef struct packed {
    logic          start;
    logic [OW-1:0] opc;
    logic [AW-1:0] rs1, rs2, rd;
    logic          imm;
    logic          rdy;
  } drv_t;

  typedef struct {
    logic [OW-1:0] opc;
    logic [AW-1:0] rs1, rs2, rd;
    logic          imm;
    int            d;
  } op_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  drv_t drv = '0;
  exp_t obs;

  logic reg1_out, reg2_out, imm_sel, alu_start, alu_out_en, reg_dest, pc_increment;
  logic busy, done, err;
  logic [AW-1:0] reg1_addr, reg2_addr, reg_dest_addr;
  logic [OW-1:0] alu_op;

  exp_t exp_q[$];
  drv_t drv_q[$];
  exp_t last_base = '0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .REG_ADDR_W(AW), .OPCODE_W(OW), .TIMEOUT(TMO), .ZERO_REG(1)
  ) dut (
    .clk(clk), .reset(reset), .start(drv.start), .opcode(drv.opc),
    .rs1(drv.rs1), .rs2(drv.rs2), .rd(drv.rd), .imm_mode(drv.imm),
    .alu_ready(drv.rdy), .reg1_out(reg1_out), .reg2_out(reg2_out),
    .reg1_addr(reg1_addr), .reg2_addr(reg2_addr), .reg_dest_addr(reg_dest_addr),
    .alu_op(alu_op), .imm_sel(imm_sel), .alu_start(alu_start),
    .alu_out_en(alu_out_en), .reg_dest(reg_dest), .pc_increment(pc_increment),
    .busy(busy), .done(done), .err(err)
  );

  assign obs = {reg1_out, reg2_out, alu_start, alu_out_en, reg_dest, pc_increment,
                busy, done, err, imm_sel, reg1_addr, reg2_addr, reg_dest_addr, alu_op};

  function automatic drv_t junk(logic st);
    drv_t v;
    v.start = st;
    v.opc   = OW'($urandom);
    v.rs1   = AW'($urandom);
    v.rs2   = AW'($urandom);
    v.rd    = AW'($urandom);
    v.imm   = 1'($urandom);
    v.rdy   = 1'b0;
    return v;
  endfunction

  function automatic op_t mk_op(int opc, int a, int b, int r, logic imm, int d);
    op_t o;
    o.opc = OW'(opc); o.rs1 = AW'(a); o.rs2 = AW'(b); o.rd = AW'(r);
    o.imm = imm; o.d = d;
    return o;
  endfunction

  function automatic op_t rand_op();
    int d;
    d = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(13, 17));
    return mk_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), 1'($urandom), d);
  endfunction

  function automatic void put(exp_t e, logic hold, logic rdy);
    drv_t v;
    v = junk(hold);
    v.rdy = rdy;
    exp_q.push_back(e);
    drv_q.push_back(v);
  endfunction

  // Idle cycle: captured fields hold, controls low; optionally presents the next request.
  function automatic void push_idle(logic st, op_t nxt);
    drv_t v;
    v = junk(st);
    if (st) begin
      v.opc = nxt.opc; v.rs1 = nxt.rs1; v.rs2 = nxt.rs2; v.rd = nxt.rd; v.imm = nxt.imm;
    end
    exp_q.push_back(last_base);
    drv_q.push_back(v);
  endfunction

  // One accepted operation: reads, launch, d cycles until the result (capped by timeout), finish.
  function automatic void push_op(op_t o, logic hold);
    exp_t base, e;
    int waits;
    base = '0;
    base.imm = o.imm; base.a1 = o.rs1; base.a2 = o.rs2; base.ad = o.rd; base.op = o.opc;
    last_base = base;
    base.busy = 1'b1;
    waits = (o.d > TMO) ? TMO : o.d;
    e = base; e.r1 = 1'b1; put(e, hold, 1'b0);
    if (!o.imm) begin
      e = base; e.r2 = 1'b1; put(e, hold, 1'b0);
    end
    e = base; e.as = 1'b1; put(e, hold, o.d == 0);
    for (int w = 1; w <= waits; w++) begin
      put(base, hold, w == o.d);
    end
    if (o.d <= TMO) begin
      e = base; e.oe = 1'b1; e.pc = 1'b1; e.rdst = (o.rd != 0); put(e, hold, 1'b0);
      e = base; e.done = 1'b1; put(e, hold, 1'b0);
    end else begin
      e = base; e.done = 1'b1; e.err = 1'b1; put(e, hold, 1'b0);
    end
  endfunction

  function automatic void clear_q();
    exp_q.delete();
    drv_q.delete();
  endfunction

  task automatic test_reset();
    #1 reset = 1'b1;
    drv = junk(1'b1);
    #2;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL reset_async got=%h want=0", obs); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL reset_hold got=%h want=0", obs); end
    reset = 1'b0;
    drv = junk(1'b0);
    @(posedge clk); #1;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL idle_after_reset got=%h want=0", obs); end
  endtask

  task automatic test_reg_reg();
    op_t o;
    clear_q();
    o = mk_op(3, 1, 2, 5, 1'b0, 0);
    push_idle(1'b1, o); push_op(o, 1'b0); push_idle(1'b0, o);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs !== exp_q[i]) begin failures++; $display("FAIL reg_reg[%0d] got=%h want=%h", i, obs, exp_q[i]); end
      drv = drv_q[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic test_immediate();
    op_t o;
    clear_q();
    o = mk_op(9, 6, 7, 4, 1'b1, 0);
    push_idle(1'b1, o); push_op(o, 1'b0); push_idle(1'b0, o);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs !== exp_q[i]) begin failures++; $display("FAIL immediate[%0d] got=%h want=%h", i, obs, exp_q[i]); end
      drv = drv_q[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wait();
    op_t o;
    clear_q();
    o = mk_op(5, 3, 4, 6, 1'b0, 3);
    push_idle(1'b1, o); push_op(o, 1'b0); push_idle(1'b0, o);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs !== exp_q[i]) begin failures++; $display("FAIL wait[%0d] got=%h want=%h", i, obs, exp_q[i]); end
      drv = drv_q[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    op_t o1, o2;
    clear_q();
    o1 = mk_op(2, 1, 3, 7, 1'b0, TMO);
    o2 = mk_op(12, 2, 5, 3, 1'b0, 1000);
    push_idle(1'b1, o1); push_op(o1, 1'b0);
    push_idle(1'b1, o2); push_op(o2, 1'b0); push_idle(1'b0, o2);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs !== exp_q[i]) begin failures++; $display("FAIL timeout[%0d] got=%h want=%h", i, obs, exp_q[i]); end
      drv = drv_q[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_reg();
    op_t o;
    clear_q();
    o = mk_op(7, 5, 6, 0, 1'b0, 1);
    push_idle(1'b1, o); push_op(o, 1'b0); push_idle(1'b0, o);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs !== exp_q[i]) begin failures++; $display("FAIL zero_reg[%0d] got=%h want=%h", i, obs, exp_q[i]); end
      drv = drv_q[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    op_t o1, o2, o3;
    clear_q();
    o1 = mk_op(1, 2, 3, 4, 1'b0, 0);
    o2 = mk_op(14, 7, 6, 5, 1'b1, 0);
    o3 = mk_op(10, 4, 1, 2, 1'b0, 2);
    push_idle(1'b1, o1); push_op(o1, 1'b1);
    push_idle(1'b1, o2); push_op(o2, 1'b1);
    push_idle(1'b1, o3); push_op(o3, 1'b1);
    push_idle(1'b0, o3);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs !== exp_q[i]) begin failures++; $display("FAIL back_to_back[%0d] got=%h want=%h", i, obs, exp_q[i]); end
      drv = drv_q[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    op_t o;
    int stop_at [2] = '{3, 4};
    for (int k = 0; k < 2; k++) begin
      clear_q();
      o = mk_op(int'($urandom_range(0, 15)), 1, 2, int'($urandom_range(1, 7)), 1'b0, 0);
      push_idle(1'b1, o); push_op(o, 1'b0);
      for (int i = 0; i <= stop_at[k]; i++) begin
        checks++;
        if (obs !== exp_q[i]) begin failures++; $display("FAIL reset_mid_pre[%0d] got=%h want=%h", i, obs, exp_q[i]); end
        if (i < stop_at[k]) begin
          drv = drv_q[i];
          @(posedge clk); #1;
        end
      end
      reset = 1'b1;
      #1;
      checks++;
      if (obs !== '0) begin failures++; $display("FAIL reset_mid_async k=%0d got=%h want=0", k, obs); end
      drv = junk(1'b1);
      @(posedge clk); #1;
      checks++;
      if (obs !== '0) begin failures++; $display("FAIL reset_mid_hold k=%0d got=%h want=0", k, obs); end
      reset = 1'b0;
      drv = junk(1'b0);
      last_base = '0;
      repeat (3) begin
        @(posedge clk); #1;
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL reset_mid_no_done k=%0d got=%h want=0", k, obs); end
      end
    end
    clear_q();
    o = rand_op();
    push_idle(1'b1, o); push_op(o, 1'b0); push_idle(1'b0, o);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs !== exp_q[i]) begin failures++; $display("FAIL after_reset[%0d] got=%h want=%h", i, obs, exp_q[i]); end
      drv = drv_q[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    op_t o;
    clear_q();
    for (int n = 0; n < 25; n++) begin
      o = rand_op();
      repeat ($urandom_range(0, 2)) push_idle(1'b0, o);
      push_idle(1'b1, o);
      push_op(o, 1'($urandom));
    end
    push_idle(1'b0, o);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs !== exp_q[i]) begin failures++; $display("FAIL random[%0d] got=%h want=%h", i, obs, exp_q[i]); end
      drv = drv_q[i];
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_reg_reg();
    test_immediate();
    test_wait();
    test_timeout();
    test_zero_reg();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
